// File: rtl/mem_bank_responder.sv
// Shared data-memory responder: round-robin arbitration of four cores onto one synchronous RAM.
// Optional feature: define MEM_ACCESS_CNT_EN to add per-core saturating access counters (access_cnt).
module mem_bank_responder #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [3:0]          req,
  input  logic [3:0]          we,
  input  logic [4*ADDR_W-1:0] addr,
  input  logic [4*DATA_W-1:0] wdata,
  output logic [3:0]          ack,
  output logic [4*DATA_W-1:0] rdata,
  output logic                busy,
  output logic [1:0]          grant_id
`ifdef MEM_ACCESS_CNT_EN
  ,
  output logic [4*16-1:0]     access_cnt
`endif
);

  localparam int unsigned NCORE = 4;
  localparam int unsigned DEPTH = 1 << ADDR_W;
  localparam int unsigned CNT_W = 16;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCESS  = 2'd1,
    RESPOND = 2'd2
  } state_t;

  state_t              state;
  logic [1:0]          last_grant;
  logic                we_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [DATA_W-1:0]   mem [DEPTH];

  logic [1:0]          pick_c;
  logic [1:0]          idx_c;
  logic                any_req_c;

  // Round-robin winner: search upward from last_grant+1; the last hit in a descending sweep is the nearest.
  always_comb begin
    pick_c    = 2'd0;
    idx_c     = 2'd0;
    any_req_c = |req;
    for (int k = int'(NCORE); k >= 1; k--) begin
      idx_c = last_grant + 2'(k);
      if (req[idx_c]) pick_c = idx_c;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      last_grant <= 2'd3;
      grant_id   <= 2'd0;
      busy       <= 1'b0;
      ack        <= '0;
      rdata      <= '0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
    end else begin
      ack <= '0;
      case (state)
        IDLE: begin
          if (any_req_c) begin
            grant_id <= pick_c;
            we_q     <= we[pick_c];
            addr_q   <= addr[pick_c*ADDR_W +: ADDR_W];
            wdata_q  <= wdata[pick_c*DATA_W +: DATA_W];
            busy     <= 1'b1;
            state    <= ACCESS;
          end
        end
        ACCESS: begin
          // Writes echo the stored data back to the requester.
          ack[grant_id]                     <= 1'b1;
          rdata[grant_id*DATA_W +: DATA_W]  <= we_q ? wdata_q : mem[addr_q];
          state                             <= RESPOND;
        end
        RESPOND: begin
          last_grant <= grant_id;
          busy       <= 1'b0;
          state      <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

  // RAM write port; a reset landing on the ACCESS edge drops the write.
  always_ff @(posedge clk) begin
    if (!rst && state == ACCESS && we_q) begin
      mem[addr_q] <= wdata_q;
    end
  end

`ifdef MEM_ACCESS_CNT_EN
  logic [NCORE-1:0][CNT_W-1:0] cnt_q;

  // Per-core completed-access counters, saturating at all ones.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (state == RESPOND && cnt_q[grant_id] != '1) begin
      cnt_q[grant_id] <= cnt_q[grant_id] + CNT_W'(1);
    end
  end

  assign access_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_mem_bank_responder.sv
// Scoreboard bench for mem_bank_responder: directed stimulus pushes expectations, a monitor checks each ack.
module tb_mem_bank_responder;

  localparam int unsigned ADDR_W = 8;
  localparam int unsigned DATA_W = 16;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic [3:0]          req = '0;
  logic [3:0]          we = '0;
  logic [4*ADDR_W-1:0] addr = '0;
  logic [4*DATA_W-1:0] wdata = '0;
  logic [3:0]          ack;
  logic [4*DATA_W-1:0] rdata;
  logic                busy;
  logic [1:0]          grant_id;
`ifdef MEM_ACCESS_CNT_EN
  logic [63:0]         access_cnt;
`endif

  mem_bank_responder #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .we         (we),
    .addr       (addr),
    .wdata      (wdata),
    .ack        (ack),
    .rdata      (rdata),
    .busy       (busy),
    .grant_id   (grant_id)
`ifdef MEM_ACCESS_CNT_EN
    ,
    .access_cnt (access_cnt)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          core;
    logic [15:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   ack_cyc[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, want, $time);
    end
  endtask

  // Drive one core's request and queue the response it must receive.
  task automatic issue(input int c, input logic w, input logic [7:0] a,
                       input logic [15:0] d, input logic [15:0] exp_d);
    exp_t e;
    e.core = c;
    e.data = exp_d;
    exp_q.push_back(e);
    req[c]                      = 1'b1;
    we[c]                       = w;
    addr[c*ADDR_W +: ADDR_W]    = a;
    wdata[c*DATA_W +: DATA_W]   = d;
  endtask

  // Wait for n acks, dropping each acked core's req; records the cycle of each ack.
  task automatic wait_acks(input int n);
    int seen = 0;
    int budget = 0;
    ack_cyc.delete();
    while (seen < n && budget < 200) begin
      @(posedge clk); #1;
      budget++;
      if (ack != 4'b0) begin
        seen++;
        ack_cyc.push_back(cyc);
        req = req & ~ack;
      end
    end
    if (seen < n) chk("ack_timeout", 64'(seen), 64'(n));
  endtask

  task automatic settle();
    int n = 0;
    @(negedge clk);
    while (busy && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (busy) chk("settle_timeout", 64'(busy), 64'd0);
  endtask

  // Monitor: every ack must match the head of the scoreboard.
  initial begin : monitor
    exp_t       e;
    logic [3:0] oh;
    forever begin
      @(posedge clk); #1;
      if (ack !== 4'b0) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_ack", 64'(ack), 64'd0);
        end else begin
          e  = exp_q.pop_front();
          oh = 4'b1 << e.core;
          chk("ack_core", 64'(ack), 64'(oh));
          chk("rdata", 64'(rdata[e.core*DATA_W +: DATA_W]), 64'(e.data));
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int t0;

    // Reset held with all four cores requesting writes 9,8,7,6 to addresses 1..4.
    for (int c = 0; c < 4; c++) issue(c, 1'b1, 8'(c + 1), 16'(9 - c), 16'(9 - c));
    repeat (2) begin
      @(posedge clk); #1;
      chk("rst_ack", 64'(ack), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_grant", 64'(grant_id), 64'd0);
      chk("rst_rdata", 64'(rdata), 64'd0);
    end
    @(negedge clk);
    rst = 1'b0;
    t0  = cyc;
    wait_acks(4);
    if (ack_cyc.size() == 4) begin
      chk("rr_first_latency", 64'(ack_cyc[0] - t0), 64'd2);
      for (int k = 1; k < 4; k++) chk("rr_spacing", 64'(ack_cyc[k] - ack_cyc[k-1]), 64'd3);
    end

    // Read-back of the round-robin writes.
    for (int k = 0; k < 4; k++) begin
      settle();
      issue(0, 1'b0, 8'(k + 1), 16'h0, 16'(9 - k));
      wait_acks(1);
    end

    // Single write then read by core 1, with latency and grant observation.
    settle();
    t0 = cyc;
    issue(1, 1'b1, 8'd2, 16'd9, 16'd9);
    wait_acks(1);
    if (ack_cyc.size() == 1) chk("wr_latency", 64'(ack_cyc[0] - t0), 64'd2);
    settle();
    t0 = cyc;
    issue(1, 1'b0, 8'd2, 16'h0, 16'd9);
    @(posedge clk); #1;
    chk("rd_busy", 64'(busy), 64'd1);
    chk("rd_grant", 64'(grant_id), 64'd1);
    wait_acks(1);
    if (ack_cyc.size() == 1) chk("rd_latency", 64'(ack_cyc[0] - t0), 64'd2);

    // Core 2 served, then cores 0 and 3 together: core 3 must win first.
    settle();
    issue(2, 1'b1, 8'h0A, 16'h0055, 16'h0055);
    wait_acks(1);
    settle();
    issue(3, 1'b1, 8'h0B, 16'h0077, 16'h0077);
    issue(0, 1'b0, 8'd1, 16'h0, 16'd9);
    wait_acks(2);
    chk("rdata1_hold", 64'(rdata[31:16]), 64'd9);

    // Address extremes, written by core 2 and read by core 3.
    settle();
    issue(2, 1'b1, 8'hFF, 16'hBEEF, 16'hBEEF);
    wait_acks(1);
    settle();
    issue(2, 1'b1, 8'h00, 16'h1111, 16'h1111);
    wait_acks(1);
    settle();
    issue(3, 1'b0, 8'hFF, 16'h0, 16'hBEEF);
    wait_acks(1);
    settle();
    issue(3, 1'b0, 8'h00, 16'h0, 16'h1111);
    wait_acks(1);

    // Reset during the ACCESS cycle of a write must suppress it.
    settle();
    issue(0, 1'b1, 8'd5, 16'h1234, 16'h1234);
    wait_acks(1);
    settle();
    req[0] = 1'b1;
    we[0] = 1'b1;
    addr[7:0] = 8'd5;
    wdata[15:0] = 16'hAAAA;
    @(posedge clk); #1;
    chk("midrst_busy", 64'(busy), 64'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("midrst_ack", 64'(ack), 64'd0);
    chk("midrst_busy_clr", 64'(busy), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    req = '0;
    repeat (4) begin
      @(posedge clk); #1;
      chk("midrst_no_ack", 64'(ack), 64'd0);
    end

    // Three reads of address 5 from core 3.
    for (int k = 0; k < 3; k++) begin
      settle();
      issue(3, 1'b0, 8'd5, 16'h0, 16'h1234);
      wait_acks(1);
    end
    settle();
`ifdef MEM_ACCESS_CNT_EN
    chk("cnt_three", access_cnt, {16'd3, 48'd0});
    dut.cnt_q[3] = 16'hFFFE;
    for (int k = 0; k < 3; k++) begin
      settle();
      issue(3, 1'b0, 8'd5, 16'h0, 16'h1234);
      wait_acks(1);
    end
    settle();
    chk("cnt_saturate", access_cnt, {16'hFFFF, 48'd0});
`endif
    issue(0, 1'b0, 8'd5, 16'h0, 16'h1234);
    wait_acks(1);

    settle();
    repeat (3) @(negedge clk);
    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
